// File: rtl/dot_prod_lag_seq.sv
// Lag-sweep sequencer for the CAF search: feeds LENGTH sample address pairs per
// lag into the pipelined dot product and hands each result downstream tagged with its lag.
module dot_prod_lag_seq #(
   parameter int LENGTH     = 8,
   parameter int NUM_LAGS   = 16,
   parameter int ADDR_BITS  = 8,
   parameter int LAG_BITS   = 4,
   parameter int SUM_I_BITS = 32,
   parameter int SUM_Q_BITS = 32
) (
   input  logic                  clk,
   input  logic                  n_reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_BITS-1:0]  lag_start,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_en,
   output logic [ADDR_BITS-1:0]  ref_addr,
   output logic [ADDR_BITS-1:0]  rx_addr,
   output logic                  m_axis_x_tvalid,
   output logic                  m_axis_y_tvalid,
   output logic                  m_axis_product_tready,
   input  logic                  s_axis_product_tvalid,
   input  logic [SUM_I_BITS-1:0] i,
   input  logic [SUM_Q_BITS-1:0] q,
   output logic                  res_tvalid,
   input  logic                  res_tready,
   output logic [SUM_I_BITS-1:0] res_i,
   output logic [SUM_Q_BITS-1:0] res_q,
   output logic [LAG_BITS-1:0]   res_lag,
   output logic                  res_last,
   output logic [2:0]            state_dbg
);

   localparam int N_BITS = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam logic [N_BITS-1:0]   N_LAST   = N_BITS'(LENGTH - 1);
   localparam logic [LAG_BITS-1:0] LAG_LAST = LAG_BITS'(NUM_LAGS - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_FEED = 3'd1,
      S_WAIT = 3'd2,
      S_OUT  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                 state;
   logic [N_BITS-1:0]      n;
   logic [LAG_BITS-1:0]    lag;
   logic [ADDR_BITS-1:0]   base;
   logic                   xy_valid;
   logic                   tready;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // res_* stay stable while res_tvalid is high and res_tready is low.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state      <= S_IDLE;
         n          <= '0;
         lag        <= '0;
         base       <= '0;
         rd_en      <= 1'b0;
         ref_addr   <= '0;
         rx_addr    <= '0;
         xy_valid   <= 1'b0;
         tready     <= 1'b0;
         res_tvalid <= 1'b0;
         res_i      <= '0;
         res_q      <= '0;
         res_lag    <= '0;
         res_last   <= 1'b0;
      end else begin
         // Sample valid trails the read strobe by the one-cycle memory latency.
         xy_valid <= rd_en;
         if (abort) begin
            state      <= S_IDLE;
            rd_en      <= 1'b0;
            xy_valid   <= 1'b0;
            tready     <= 1'b0;
            res_tvalid <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     base     <= lag_start;
                     lag      <= '0;
                     n        <= '0;
                     rd_en    <= 1'b1;
                     ref_addr <= '0;
                     rx_addr  <= lag_start;
                     state    <= S_FEED;
                  end
               end
               S_FEED: begin
                  if (n == N_LAST) begin
                     rd_en  <= 1'b0;
                     tready <= 1'b1;
                     state  <= S_WAIT;
                  end else begin
                     n        <= n + N_BITS'(1);
                     ref_addr <= ADDR_BITS'(n) + ADDR_BITS'(1);
                     rx_addr  <= base + ADDR_BITS'(lag) + ADDR_BITS'(n) + ADDR_BITS'(1);
                  end
               end
               S_WAIT: begin
                  if (s_axis_product_tvalid) begin
                     res_i      <= i;
                     res_q      <= q;
                     res_lag    <= lag;
                     res_last   <= (lag == LAG_LAST);
                     tready     <= 1'b0;
                     res_tvalid <= 1'b1;
                     state      <= S_OUT;
                  end
               end
               S_OUT: begin
                  if (res_tready) begin
                     res_tvalid <= 1'b0;
                     if (lag == LAG_LAST) begin
                        state <= S_DONE;
                     end else begin
                        lag      <= lag + LAG_BITS'(1);
                        n        <= '0;
                        rd_en    <= 1'b1;
                        ref_addr <= '0;
                        rx_addr  <= base + ADDR_BITS'(lag) + ADDR_BITS'(1);
                        state    <= S_FEED;
                     end
                  end
               end
               S_DONE:  state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy                  = (state != S_IDLE);
   assign done                  = (state == S_DONE);
   assign m_axis_x_tvalid       = xy_valid;
   assign m_axis_y_tvalid       = xy_valid;
   assign m_axis_product_tready = tready;
   assign state_dbg             = state;

endmodule
